// File: rtl/mem_arbiter_pkg.sv
// Shared memory-side package for the cache blocks.
// Holds the burst arbiter state encoding and the default line geometry
// (burst length in words, word width) used by the cache-line adapter,
// the arbiter and the memory wrapper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int MEM_BURST_LEN = 8;
  localparam int MEM_WORD_W    = 32;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port burst arbiter in front of main memory.
// The instruction side (line reads) and the data side (line reads or
// writebacks) compete for one memory port. Arbitration happens only in
// IDLE; ties go round-robin, starting with the data side. A granted burst
// always runs BURST_LEN beats, paced by mm_valid, and ends with a one-cycle
// DONE state that pulses the owner's done strobe.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   req_i, addr_i         instruction-side line read request / address
//   req_d, we_d, addr_d,  data-side request, we_d=1 selects writeback,
//   wdata_d               writeback word currently presented
//   gnt_i, gnt_d          burst owner (at most one high)
//   rvalid, rdata, beat   read beat strobe, data and beat index
//   wack_d                writeback word accepted, present the next one
//   done_i, done_d        one-cycle burst-complete pulses
//   mm_re, mm_we, mm_addr, main-memory request, word address, write data
//   mm_din
//   mm_dout, mm_valid     main-memory read data and beat handshake
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BURST_LEN = MEM_BURST_LEN,
  parameter int ADDR_W    = 32,
  parameter int WORD_W    = MEM_WORD_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_i,
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic                         req_d,
  input  logic                         we_d,
  input  logic [ADDR_W-1:0]            addr_d,
  input  logic [WORD_W-1:0]            wdata_d,
  output logic                         gnt_i,
  output logic                         gnt_d,
  output logic                         rvalid,
  output logic [WORD_W-1:0]            rdata,
  output logic [$clog2(BURST_LEN)-1:0] beat,
  output logic                         wack_d,
  output logic                         done_i,
  output logic                         done_d,
  output logic                         mm_re,
  output logic                         mm_we,
  output logic [ADDR_W-1:0]            mm_addr,
  output logic [WORD_W-1:0]            mm_din,
  input  logic [WORD_W-1:0]            mm_dout,
  input  logic                         mm_valid
);

  localparam int                BEAT_W    = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  // Byte offset within a line: beat index plus the 2-bit word offset.
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BURST_LEN * 4 - 1);

  arb_state_t        state, state_nxt;
  logic              owner_d;     // 1: data side owns the current burst
  logic              last_d;      // 1: data side won the previous grant
  logic [ADDR_W-1:0] base_addr;
  logic              win_d;
  logic              any_req;
  logic              busy;
  logic              last_beat;
  logic [ADDR_W-1:0] addr_sel;

  assign any_req   = req_i | req_d;
  // Data wins when alone, or on a tie when instruction was granted last.
  assign win_d     = req_d & (~req_i | ~last_d);
  assign addr_sel  = win_d ? addr_d : addr_i;
  assign busy      = (state == READ) || (state == WRITE);
  assign last_beat = busy && mm_valid && (beat == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_i     = 1'b0;
    gnt_d     = 1'b0;
    mm_re     = 1'b0;
    mm_we     = 1'b0;
    rvalid    = 1'b0;
    rdata     = '0;
    wack_d    = 1'b0;
    mm_din    = '0;
    done_i    = 1'b0;
    done_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = (win_d && we_d) ? WRITE : READ;
        end
      end
      READ: begin
        gnt_i  = ~owner_d;
        gnt_d  = owner_d;
        mm_re  = 1'b1;
        rvalid = mm_valid;
        rdata  = mm_dout;
        if (last_beat) begin
          state_nxt = DONE;
        end
      end
      WRITE: begin
        gnt_d  = 1'b1;
        mm_we  = 1'b1;
        mm_din = wdata_d;
        wack_d = mm_valid;
        if (last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done_i    = ~owner_d;
        done_d    = owner_d;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant-time capture of owner and line base; beat counter runs only
  // while a burst is active, so mm_valid in IDLE/DONE is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_d   <= 1'b0;
      last_d    <= 1'b0;
      beat      <= '0;
      base_addr <= '0;
    end else if (state == IDLE && any_req) begin
      owner_d   <= win_d;
      last_d    <= win_d;
      beat      <= '0;
      base_addr <= addr_sel & ~LINE_MASK;
    end else if (busy && mm_valid) begin
      beat <= last_beat ? '0 : beat + 1'b1;
    end
  end

  assign mm_addr = base_addr + ADDR_W'({beat, 2'b00});

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int BL = 8;
  localparam int AW = 32;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_i, req_d, we_d;
  logic [AW-1:0] addr_i, addr_d;
  logic [WW-1:0] wdata_d;
  logic          gnt_i, gnt_d, rvalid, wack_d, done_i, done_d;
  logic [WW-1:0] rdata;
  logic [2:0]    beat;
  logic          mm_re, mm_we, mm_valid;
  logic [AW-1:0] mm_addr;
  logic [WW-1:0] mm_din, mm_dout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  beat;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    n_done_i, n_done_d, n_re, n_we, n_viol;

  mem_arbiter #(.BURST_LEN(BL), .ADDR_W(AW), .WORD_W(WW)) dut (
    .clk(clk), .reset(reset),
    .req_i(req_i), .addr_i(addr_i),
    .req_d(req_d), .we_d(we_d), .addr_d(addr_d), .wdata_d(wdata_d),
    .gnt_i(gnt_i), .gnt_d(gnt_d),
    .rvalid(rvalid), .rdata(rdata), .beat(beat),
    .wack_d(wack_d), .done_i(done_i), .done_d(done_d),
    .mm_re(mm_re), .mm_we(mm_we), .mm_addr(mm_addr), .mm_din(mm_din),
    .mm_dout(mm_dout), .mm_valid(mm_valid)
  );

  always #5 clk = ~clk;

  // Main-memory contents: a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDA7A_5EED;
  endfunction

  assign mm_dout = mem_word(mm_addr);

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, limit 500000");
    $fatal(1, "timeout");
  end

  task automatic push_burst(input logic [31:0] a, input bit wr, input logic [31:0] wstart);
    logic [31:0] base;
    beat_t e;
    base = a & ~32'(BL * 4 - 1);
    for (int k = 0; k < BL; k++) begin
      e.addr = base + 32'(4 * k);
      e.beat = 3'(k);
      e.data = wr ? (wstart + 32'(k)) : mem_word(e.addr);
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    n_done_i = 0; n_done_d = 0; n_re = 0; n_we = 0; n_viol = 0;
  endtask

  // Drives mm_valid (high on the last cycle of each period) and records
  // DUT activity; entered and left at posedge+1.
  task automatic run_cycles(input int max_cyc, input int period, input int drop_beat,
                            input bit stop_on_done);
    bit seen;
    seen = 0;
    for (int c = 0; c < max_cyc; c++) begin
      mm_valid = ((c % period) == period - 1);
      #1;
      if (rvalid) obs_q.push_back('{mm_addr, beat, rdata});
      if (wack_d) begin
        obs_q.push_back('{mm_addr, beat, mm_din});
        wdata_d = wdata_d + 1;
      end
      if ((rvalid && !(gnt_i || gnt_d)) || (wack_d && !gnt_d)) n_viol++;
      if (mm_re) n_re++;
      if (mm_we) n_we++;
      if (done_i) n_done_i++;
      if (done_d) n_done_d++;
      if (done_i || done_d) seen = 1;
      if ((rvalid || wack_d) && drop_beat >= 0 && int'(beat) == drop_beat) begin
        req_i = 0;
        req_d = 0;
      end
      @(posedge clk); #1;
      if (stop_on_done && seen) break;
    end
    mm_valid = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; req_i = 0; req_d = 0; we_d = 0; addr_i = '0; addr_d = '0;
    wdata_d = '0; mm_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({gnt_i, gnt_d, mm_re, mm_we, rvalid, wack_d, done_i, done_d} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000000",
               {gnt_i, gnt_d, mm_re, mm_we, rvalid, wack_d, done_i, done_d});
    end
    checks++;
    if (beat !== 3'd0) begin errors++; $display("FAIL reset_beat: got %0d required 0", beat); end
    checks++;
    if (mm_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h required 0", mm_addr); end
    reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    beat_t e, o;
    addr_i = 32'h0000_0044; req_i = 1;
    @(posedge clk); #1;
    checks++;
    if (!(gnt_i === 1 && gnt_d === 0 && mm_re === 1 && mm_we === 0)) begin
      errors++;
      $display("FAIL read_grant: gnt_i=%b gnt_d=%b mm_re=%b mm_we=%b required 1 0 1 0",
               gnt_i, gnt_d, mm_re, mm_we);
    end
    push_burst(32'h44, 0, 0);
    clear_obs();
    addr_i = 32'hFFFF_FF00;
    run_cycles(20, 1, -1, 1);
    req_i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL read_beat_missing: got no beat, required beat %0d", e.beat);
      end else begin
        o = obs_q.pop_front();
        if (o.addr !== e.addr || o.beat !== e.beat || o.data !== e.data) begin
          errors++;
          $display("FAIL read_beat: got addr %h beat %0d data %h required %h %0d %h",
                   o.addr, o.beat, o.data, e.addr, e.beat, e.data);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL read_extra: got %0d extra beats required 0", obs_q.size()); end
    checks++;
    if (n_done_i != 1 || n_done_d != 0) begin
      errors++; $display("FAIL read_done: got done_i %0d done_d %0d required 1 0", n_done_i, n_done_d);
    end
    checks++;
    if (n_re != 8) begin errors++; $display("FAIL read_re_cycles: got %0d required 8", n_re); end
    checks++;
    if (n_viol != 0) begin errors++; $display("FAIL read_strobe_owner: got %0d required 0", n_viol); end
    checks++;
    if ({gnt_i, gnt_d, mm_re, done_i} !== 4'b0000) begin
      errors++; $display("FAIL read_idle: got %b required 0000", {gnt_i, gnt_d, mm_re, done_i});
    end
  endtask

  task automatic test_tie();
    reset = 1; req_i = 1; req_d = 1; we_d = 0;
    addr_i = 32'h0000_0200; addr_d = 32'h0000_0100;
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    checks++;
    if (!(gnt_d === 1 && gnt_i === 0 && mm_addr === 32'h100)) begin
      errors++; $display("FAIL tie_first: gnt_d=%b gnt_i=%b addr %h required 1 0 00000100",
                         gnt_d, gnt_i, mm_addr);
    end
    clear_obs();
    run_cycles(20, 1, -1, 1);
    checks++;
    if (n_done_d != 1 || n_done_i != 0) begin
      errors++; $display("FAIL tie_done_d: got done_d %0d done_i %0d required 1 0", n_done_d, n_done_i);
    end
    checks++;
    if (gnt_i !== 0 || gnt_d !== 0) begin
      errors++; $display("FAIL tie_gap: gnt_i=%b gnt_d=%b required 0 0", gnt_i, gnt_d);
    end
    @(posedge clk); #1;
    checks++;
    if (!(gnt_i === 1 && gnt_d === 0 && mm_addr === 32'h200)) begin
      errors++; $display("FAIL tie_second: gnt_i=%b gnt_d=%b addr %h required 1 0 00000200",
                         gnt_i, gnt_d, mm_addr);
    end
    clear_obs();
    run_cycles(20, 1, -1, 1);
    checks++;
    if (n_done_i != 1) begin errors++; $display("FAIL tie_done_i: got %0d required 1", n_done_i); end
    @(posedge clk); #1;
    checks++;
    if (!(gnt_d === 1 && gnt_i === 0)) begin
      errors++; $display("FAIL tie_third: gnt_d=%b gnt_i=%b required 1 0", gnt_d, gnt_i);
    end
    req_i = 0; req_d = 0;
    clear_obs();
    run_cycles(20, 1, -1, 1);
  endtask

  task automatic test_writeback();
    beat_t e, o;
    req_d = 1; we_d = 1; addr_d = 32'h0000_6020; wdata_d = 32'h0000_1000;
    @(posedge clk); #1;
    checks++;
    if (!(gnt_d === 1 && mm_we === 1 && mm_re === 0)) begin
      errors++; $display("FAIL wb_grant: gnt_d=%b mm_we=%b mm_re=%b required 1 1 0", gnt_d, mm_we, mm_re);
    end
    push_burst(32'h6020, 1, 32'h1000);
    clear_obs();
    addr_d = 32'hFFFF_0000; we_d = 0;
    run_cycles(40, 2, -1, 1);
    req_d = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL wb_beat_missing: got no beat, required beat %0d", e.beat);
      end else begin
        o = obs_q.pop_front();
        if (o.addr !== e.addr || o.beat !== e.beat || o.data !== e.data) begin
          errors++;
          $display("FAIL wb_beat: got addr %h beat %0d din %h required %h %0d %h",
                   o.addr, o.beat, o.data, e.addr, e.beat, e.data);
        end
      end
    end
    checks++;
    if (n_we != 16) begin errors++; $display("FAIL wb_we_cycles: got %0d required 16", n_we); end
    checks++;
    if (n_done_d != 1 || n_done_i != 0) begin
      errors++; $display("FAIL wb_done: got done_d %0d done_i %0d required 1 0", n_done_d, n_done_i);
    end
    checks++;
    if (n_viol != 0 || obs_q.size() != 0) begin
      errors++; $display("FAIL wb_strobes: got viol %0d extra %0d required 0 0", n_viol, obs_q.size());
    end
  endtask

  task automatic test_drop();
    beat_t e, o;
    req_i = 1; addr_i = 32'h1234_5678;
    @(posedge clk); #1;
    push_burst(32'h1234_5678, 0, 0);
    clear_obs();
    run_cycles(20, 1, 3, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL drop_beat_missing: got no beat, required beat %0d", e.beat);
      end else begin
        o = obs_q.pop_front();
        if (o.addr !== e.addr || o.beat !== e.beat || o.data !== e.data) begin
          errors++;
          $display("FAIL drop_beat: got addr %h beat %0d data %h required %h %0d %h",
                   o.addr, o.beat, o.data, e.addr, e.beat, e.data);
        end
      end
    end
    checks++;
    if (n_done_i != 1) begin errors++; $display("FAIL drop_done: got %0d required 1", n_done_i); end
  endtask

  task automatic test_reset_mid();
    beat_t e, o;
    bit hit;
    hit = 0;
    req_i = 1; addr_i = 32'h0000_0800;
    @(posedge clk); #1;
    mm_valid = 1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (beat == 3'd5) begin hit = 1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rstmid_reach: beat 5 not seen, got %0d", beat); end
    reset = 1; req_i = 0;
    @(posedge clk); #1;
    mm_valid = 0;
    checks++;
    if ({mm_re, gnt_i, done_i, done_d} !== 4'b0000 || beat !== 3'd0) begin
      errors++; $display("FAIL rstmid_abort: re,gnt_i,done_i,done_d=%b beat %0d required 0000 0",
                         {mm_re, gnt_i, done_i, done_d}, beat);
    end
    reset = 0;
    req_d = 1; we_d = 0; addr_d = 32'h0000_2000;
    @(posedge clk); #1;
    checks++;
    if (!(gnt_d === 1 && beat === 3'd0 && mm_addr === 32'h2000 && done_i === 0)) begin
      errors++; $display("FAIL rstmid_restart: gnt_d=%b beat %0d addr %h done_i=%b required 1 0 00002000 0",
                         gnt_d, beat, mm_addr, done_i);
    end
    push_burst(32'h2000, 0, 0);
    clear_obs();
    run_cycles(20, 1, -1, 1);
    req_d = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL rstmid_beat_missing: got no beat, required beat %0d", e.beat);
      end else begin
        o = obs_q.pop_front();
        if (o.addr !== e.addr || o.beat !== e.beat || o.data !== e.data) begin
          errors++;
          $display("FAIL rstmid_beat: got addr %h beat %0d data %h required %h %0d %h",
                   o.addr, o.beat, o.data, e.addr, e.beat, e.data);
        end
      end
    end
    checks++;
    if (n_done_d != 1 || n_done_i != 0) begin
      errors++; $display("FAIL rstmid_done: got done_d %0d done_i %0d required 1 0", n_done_d, n_done_i);
    end
  endtask

  task automatic test_stray_valid();
    req_i = 0; req_d = 0;
    do_reset();
    mm_valid = 1;
    #1;
    checks++;
    if (rvalid !== 0 || wack_d !== 0 || beat !== 3'd0) begin
      errors++; $display("FAIL stray_strobe: rvalid=%b wack_d=%b beat %0d required 0 0 0", rvalid, wack_d, beat);
    end
    @(posedge clk); #1;
    mm_valid = 0;
    checks++;
    if (beat !== 3'd0 || gnt_i !== 0 || gnt_d !== 0 || mm_re !== 0) begin
      errors++; $display("FAIL stray_state: beat %0d gnt_i=%b gnt_d=%b mm_re=%b required 0 0 0 0",
                         beat, gnt_i, gnt_d, mm_re);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_writeback();
    test_drop();
    test_reset_mid();
    test_stray_valid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
